// File: rtl/canny_frame_ctrl_pkg.sv
// Shared types and size helpers for the Canny frame sequencer (package canny_pkg).
package canny_pkg;

    // Frame sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Number of pixels in one frame.
    function automatic int unsigned pixel_count(input int unsigned width, input int unsigned height);
        return width * height;
    endfunction

    // Width of a counter that must be able to hold the value PIXELS itself.
    function automatic int count_width(input int unsigned pixels);
        return $clog2(pixels + 1);
    endfunction

endpackage

// File: rtl/canny_frame_ctrl_if.sv
// Stream/FIFO bus between host, sequencer, pipeline FIFOs and sink.
//
// Handshake rules: on the host side a pixel moves when src_valid & src_ready are
// both high at a rising edge (src_ready never depends on src_ready itself, only on
// src_valid, image_full and sequencer state). On the sink side a pixel moves when
// sink_valid & sink_ready are both high; that same cycle img_out_rd_en pops the
// first-word-fall-through output FIFO. image_wr_en/img_out_rd_en are single-cycle
// strobes per transferred word.
interface canny_frame_ctrl_if;
    logic        src_valid;
    logic        src_ready;
    logic [23:0] src_data;
    logic        image_full;
    logic        image_wr_en;
    logic [23:0] image_din;
    logic        img_out_empty;
    logic        img_out_rd_en;
    logic [7:0]  img_out_dout;
    logic        sink_valid;
    logic        sink_ready;
    logic [7:0]  sink_data;
    logic        sink_last;

    // Sequencer side.
    modport master (
        input  src_valid, src_data, image_full, img_out_empty, img_out_dout, sink_ready,
        output src_ready, image_wr_en, image_din, img_out_rd_en, sink_valid, sink_data, sink_last
    );

    // Host / FIFO / sink side.
    modport slave (
        output src_valid, src_data, image_full, img_out_empty, img_out_dout, sink_ready,
        input  src_ready, image_wr_en, image_din, img_out_rd_en, sink_valid, sink_data, sink_last
    );
endinterface

// File: rtl/canny_frame_ctrl_frame_counter.sv
// Saturating pixel counter with synchronous clear; o_at_limit flags count == LIMIT.
module frame_counter #(
    parameter int          CNT_W = 19,
    parameter int unsigned LIMIT = 388800
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count,
    output logic             o_at_limit
);

    logic [CNT_W-1:0] r_count;
    logic             w_at_limit;

    assign w_at_limit = (r_count == CNT_W'(LIMIT));
    assign o_at_limit = w_at_limit;
    assign o_count    = r_count;

    // Count increments, holding at LIMIT; clear has priority.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !w_at_limit) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/canny_frame_ctrl.sv
// Canny frame sequencer: admits one WIDTH x HEIGHT frame per start, drains the same
// number of edge pixels to the sink, flags the last one and pulses done.
// Optional stall watchdog: define CANNY_FRAME_TIMEOUT_EN.
module canny_frame_ctrl
    import canny_pkg::*;
#(
    parameter int unsigned WIDTH          = 720,
    parameter int unsigned HEIGHT         = 540,
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    localparam int unsigned PIXELS        = pixel_count(WIDTH, HEIGHT),
    localparam int          CNT_W         = count_width(PIXELS)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    output logic                o_busy,
    output logic                o_done,
    output logic [15:0]         o_frame_cnt,
    output logic                o_timeout_err,
    output state_t              o_state,
    output logic [CNT_W-1:0]    o_in_cnt,
    output logic [CNT_W-1:0]    o_out_cnt,
    canny_frame_ctrl_if.master  bus
);

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic [15:0]      r_frame_cnt;
    logic             r_timeout_err;

    logic             w_start_ok;
    logic             w_open;
    logic             w_accept;
    logic             w_active;
    logic             w_sink_valid;
    logic             w_pop;
    logic             w_in_full;
    logic             w_out_final;
    logic             w_stall_hit;
    logic [CNT_W-1:0] w_in_cnt;
    logic [CNT_W-1:0] w_out_cnt;

    assign w_start_ok = i_start && (r_state == IDLE);

    // Input side: open only while RUN still owes pixels.
    assign w_open             = (r_state == RUN) && !w_in_full;
    assign w_accept           = bus.src_valid && !bus.image_full && w_open;
    assign bus.src_ready      = w_accept;
    assign bus.image_wr_en    = w_accept;
    assign bus.image_din      = bus.src_data;

    // Output side: drains in RUN and DRAIN.
    assign w_active           = (r_state == RUN) || (r_state == DRAIN);
    assign w_sink_valid       = !bus.img_out_empty && w_active;
    assign w_pop              = w_sink_valid && bus.sink_ready;
    assign bus.sink_valid     = w_sink_valid;
    assign bus.img_out_rd_en  = w_pop;
    assign bus.sink_data      = bus.img_out_dout;
    assign bus.sink_last      = w_sink_valid && w_out_final;

    // Input pixel count; at_limit means the whole frame has been admitted.
    frame_counter #(.CNT_W(CNT_W), .LIMIT(PIXELS)) u_in_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (w_start_ok),
        .i_inc      (w_accept),
        .o_count    (w_in_cnt),
        .o_at_limit (w_in_full)
    );

    // Output pixel count; stops at PIXELS-1 so at_limit marks the final pixel.
    frame_counter #(.CNT_W(CNT_W), .LIMIT(PIXELS - 1)) u_out_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (w_start_ok),
        .i_inc      (w_pop),
        .o_count    (w_out_cnt),
        .o_at_limit (w_out_final)
    );

`ifdef CANNY_FRAME_TIMEOUT_EN
    localparam int ST_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [ST_W-1:0] r_stall_cnt;

    // The last idle cycle before reaching TIMEOUT_CYCLES aborts the frame.
    assign w_stall_hit = w_active && !w_pop && (r_stall_cnt == ST_W'(TIMEOUT_CYCLES - 1));

    // Stall counter: counts active cycles without an output pop.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
        end else if (w_start_ok || w_pop || !w_active) begin
            r_stall_cnt <= '0;
        end else begin
            r_stall_cnt <= r_stall_cnt + ST_W'(1);
        end
    end
`else
    assign w_stall_hit = 1'b0;
`endif

    // Frame sequencer with registered busy/done/frame count/error.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_frame_cnt   <= 16'd0;
            r_timeout_err <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state       <= RUN;
                        r_busy        <= 1'b1;
                        r_timeout_err <= 1'b0;
                    end
                end
                RUN, DRAIN: begin
                    if (w_stall_hit) begin
                        r_state       <= IDLE;
                        r_busy        <= 1'b0;
                        r_timeout_err <= 1'b1;
                    end else if (w_pop && w_out_final) begin
                        r_state     <= DONE;
                        r_done      <= 1'b1;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                    end else if (r_state == RUN && w_in_full) begin
                        r_state <= DRAIN;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_frame_cnt   = r_frame_cnt;
    assign o_timeout_err = r_timeout_err;
    assign o_state       = r_state;
    assign o_in_cnt      = w_in_cnt;
    assign o_out_cnt     = w_out_cnt;

endmodule

// File: tb/tb_canny_frame_ctrl.sv
// Directed bench for canny_frame_ctrl at WIDTH=4, HEIGHT=3 with a loopback FIFO model.
module tb_canny_frame_ctrl;
    import canny_pkg::*;

    localparam int PIXELS = 12;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_frame_cnt;
    logic        o_timeout_err;
    state_t      o_state;
    logic [3:0]  o_in_cnt;
    logic [3:0]  o_out_cnt;

    canny_frame_ctrl_if bus ();

    canny_frame_ctrl #(.WIDTH(4), .HEIGHT(3), .TIMEOUT_CYCLES(16)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (i_start),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_frame_cnt   (o_frame_cnt),
        .o_timeout_err (o_timeout_err),
        .o_state       (o_state),
        .o_in_cnt      (o_in_cnt),
        .o_out_cnt     (o_out_cnt),
        .bus           (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    logic [7:0]  exp_q[$];
    logic [7:0]  out_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          src_left = 0;
    logic [23:0] next_pix = 24'h102030;
    bit          full_toggle = 0;
    bit          sink_hold = 0;
    int          pop_limit = 1000;
    int          n_wr, n_pop, n_done, n_full_viol, n_ready_viol, n_extra;
    int          cyc = 0;
    int          cyc_last_pop, cyc_done;
    int          bad, p0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_stats();
        n_wr = 0; n_pop = 0; n_done = 0; n_full_viol = 0; n_ready_viol = 0; n_extra = 0;
        cyc_last_pop = 0; cyc_done = 0;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && n_done == 0; i++) tick();
        check("done_seen", (n_done > 0), 1);
    endtask

    // driver: host source, full toggling, sink ready and FWFT output FIFO model
    always @(negedge clk) begin
        bus.src_valid     = (src_left > 0);
        bus.src_data      = next_pix;
        bus.image_full    = full_toggle ? ~bus.image_full : 1'b0;
        bus.sink_ready    = ~sink_hold;
        bus.img_out_empty = (out_q.size() == 0) || (n_pop >= pop_limit);
        bus.img_out_dout  = (out_q.size() > 0) ? out_q[0] : 8'h00;
    end

    // monitor: loopback model, expected queue and sink checks
    always @(posedge clk) begin
        if (bus.image_wr_en) begin
            if (bus.image_full) n_full_viol++;
            out_q.push_back(bus.image_din[7:0] ^ 8'hA5);
            exp_q.push_back(bus.src_data[7:0] ^ 8'hA5);
            n_wr++;
            src_left--;
            next_pix = next_pix + 24'h010203;
        end
        if (bus.img_out_rd_en) begin
            if (!bus.sink_ready || bus.img_out_empty) n_ready_viol++;
            n_pop++;
            if (exp_q.size() > 0) check("sink_data", bus.sink_data, exp_q.pop_front());
            else n_extra++;
            check("sink_last", bus.sink_last, (n_pop == PIXELS));
            if (out_q.size() > 0) void'(out_q.pop_front());
            cyc_last_pop = cyc;
        end
        if (o_done) begin
            n_done++;
            cyc_done = cyc;
        end
        cyc++;
    end

    initial begin
        rst = 1'b1; i_start = 1'b0;
        bus.src_valid = 1'b0; bus.src_data = '0; bus.image_full = 1'b0;
        bus.sink_ready = 1'b1; bus.img_out_empty = 1'b1; bus.img_out_dout = '0;
        clear_stats();
        repeat (3) tick();

        // reset values
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_timeout_err", o_timeout_err, 0);
        check("rst_src_ready", bus.src_ready, 0);
        check("rst_wr_en", bus.image_wr_en, 0);
        check("rst_rd_en", bus.img_out_rd_en, 0);
        check("rst_sink_valid", bus.sink_valid, 0);
        check("rst_sink_last", bus.sink_last, 0);
        check("rst_frame_cnt", o_frame_cnt, 0);
        rst = 1'b0;
        tick();

        // idle: source offers pixels without a start
        src_left = 20; bad = 0;
        repeat (20) begin
            tick();
            if (bus.src_ready || o_busy) bad++;
        end
        check("idle_quiet", bad, 0);
        check("idle_wr", n_wr, 0);
        src_left = 0;
        tick();

        // single frame, no backpressure
        clear_stats();
        pulse_start();
        check("busy_after_start", o_busy, 1);
        src_left = PIXELS;
        wait_done(200);
        check("f1_busy_after_done", o_busy, 0);
        check("f1_wr", n_wr, PIXELS);
        check("f1_pop", n_pop, PIXELS);
        check("f1_done_latency", cyc_done - cyc_last_pop, 1);
        check("f1_frame_cnt", o_frame_cnt, 1);
        check("f1_exp_empty", exp_q.size(), 0);
        check("f1_no_timeout", o_timeout_err, 0);
        repeat (3) tick();
        check("f1_single_done", n_done, 1);

        // overrun guard: 20 offered, 12 accepted
        clear_stats();
        src_left = 20;
        pulse_start();
        wait_done(200);
        check("ovr_wr", n_wr, PIXELS);
        check("ovr_left", src_left, 8);
        check("ovr_frame_cnt", o_frame_cnt, 2);
        src_left = 0;
        tick();

        // backpressure on both sides
        clear_stats();
        full_toggle = 1;
        pulse_start();
        src_left = PIXELS;
        repeat (6) tick();
        sink_hold = 1;
        tick();
        p0 = n_pop;
        repeat (4) tick();
        check("bp_hold_no_pop", n_pop, p0);
        sink_hold = 0;
        wait_done(300);
        full_toggle = 0;
        check("bp_wr", n_wr, PIXELS);
        check("bp_pop", n_pop, PIXELS);
        check("bp_full_viol", n_full_viol, 0);
        check("bp_ready_viol", n_ready_viol, 0);
        check("bp_extra", n_extra, 0);
        repeat (3) tick();
        check("bp_single_done", n_done, 1);
        check("bp_frame_cnt", o_frame_cnt, 3);

        // reset mid-frame
        clear_stats();
        pulse_start();
        src_left = PIXELS;
        repeat (6) tick();
        rst = 1'b1;
        src_left = 0;
        out_q.delete();
        exp_q.delete();
        tick();
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_frame_cnt", o_frame_cnt, 0);
        check("mid_rst_in_cnt", o_in_cnt, 0);
        rst = 1'b0;
        tick();

        // start in RUN and in DONE ignored; start right after DONE accepted
        clear_stats();
        pulse_start();
        src_left = PIXELS;
        repeat (3) tick();
        pulse_start();
        for (int i = 0; i < 200 && !o_done; i++) tick();
        check("dn_done_reached", o_done, 1);
        pulse_start();
        check("dn_start_ignored", o_busy, 0);
        check("dn_wr", n_wr, PIXELS);
        check("dn_pop", n_pop, PIXELS);
        check("dn_frame_cnt", o_frame_cnt, 1);
        clear_stats();
        pulse_start();
        check("f2_busy", o_busy, 1);
        src_left = PIXELS;
        wait_done(200);
        check("f2_wr", n_wr, PIXELS);
        check("f2_frame_cnt", o_frame_cnt, 2);

        // stall: the output model stops after 5 pixels
        clear_stats();
        pop_limit = 5;
        pulse_start();
        src_left = PIXELS;
`ifdef CANNY_FRAME_TIMEOUT_EN
        for (int i = 0; i < 200 && !o_timeout_err; i++) tick();
        check("to_err", o_timeout_err, 1);
        check("to_busy", o_busy, 0);
        check("to_no_done", n_done, 0);
        check("to_frame_cnt", o_frame_cnt, 2);
        check("to_pop", n_pop, 5);
        check("to_stall_len", cyc - cyc_last_pop, 17);
        pop_limit = 1000;
        repeat (4) tick();
        check("to_idle_no_pop", n_pop, 5);
        pulse_start();
        check("to_err_cleared", o_timeout_err, 0);
        check("to_restart_busy", o_busy, 1);
`else
        repeat (40) tick();
        check("stall_busy", o_busy, 1);
        check("stall_no_err", o_timeout_err, 0);
        check("stall_no_done", n_done, 0);
        check("stall_pop", n_pop, 5);
`endif
        rst = 1'b1;
        src_left = 0;
        out_q.delete();
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/canny_frame_ctrl.md
# canny_frame_ctrl

Frame sequencer for the Canny edge-detection pipeline. Sits between the host stream and the pipeline top: admits exactly one frame of WIDTH×HEIGHT RGB pixels into the image input FIFO per start command, drains exactly WIDTH×HEIGHT edge pixels from the output FIFO to the sink, marks the last pixel, and reports completion. Provides frame-level sequencing and optional stall detection; it does no pixel arithmetic.

## Interface
- WIDTH, 720, image width in pixels
- HEIGHT, 540, image height in pixels
- TIMEOUT_CYCLES, 65536, stall limit in cycles; used only when the timeout feature is compiled in
- clock  in  1  single system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin one frame; honoured only in IDLE
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse when a frame completes
- frame_cnt  out  16  completed-frame count; wraps at 2^16
- timeout_err  out  1  sticky stall flag
- src_valid  in  1  host pixel valid
- src_ready  out  1  host pixel accepted this cycle
- src_data  in  24  host RGB pixel
- image_full  in  1  pipeline input FIFO full
- image_wr_en  out  1  write strobe to the input FIFO
- image_din  out  24  data to the input FIFO; equals src_data
- img_out_empty  in  1  pipeline output FIFO empty
- img_out_rd_en  out  1  pop strobe to the output FIFO
- img_out_dout  in  8  output FIFO head; first-word-fall-through, valid while not empty
- sink_valid  out  1  edge pixel valid to the sink
- sink_ready  in  1  sink accepts
- sink_data  out  8  edge pixel; equals img_out_dout
- sink_last  out  1  high with the final pixel of the frame

## Operation
- PIXELS = WIDTH*HEIGHT. in_cnt and out_cnt are each $clog2(PIXELS+1) bits wide (19 bits at the defaults).
- States:
  - IDLE: start → RUN; clear in_cnt, out_cnt and timeout_err.
  - RUN: input side open. When in_cnt reaches PIXELS → DRAIN.
  - DRAIN: input side closed; output side continues.
  - DONE: lasts one cycle; done=1, frame_cnt+1, then → IDLE.
- Input side is open only in RUN with in_cnt < PIXELS:
  - accept = src_valid & ~image_full & open.
  - src_ready = image_wr_en = accept; in_cnt increments on accept.
- Output side is active in RUN and DRAIN:
  - sink_valid = ~img_out_empty & active.
  - img_out_rd_en = sink_valid & sink_ready; out_cnt increments on each pop.
  - sink_last = sink_valid & (out_cnt == PIXELS-1).
- A pop with out_cnt == PIXELS-1 moves the FSM to DONE, from either RUN or DRAIN. Output completion implies input completion.
- start outside IDLE is ignored, including start during DONE. start in the cycle after DONE is accepted.
- In IDLE the output FIFO is never popped, even if it is non-empty.
- Reset mid-frame: FSM → IDLE; counters, frame_cnt and timeout_err clear. Pipeline FIFOs are reset by the same reset net.

## Timing
- Reset values: busy, done, timeout_err, src_ready, image_wr_en, img_out_rd_en, sink_valid and sink_last are 0; frame_cnt = 0.
- src_ready/image_wr_en and sink_valid/img_out_rd_en are combinational from registered state and counters plus the same-cycle inputs. Zero added latency on either path.
- start sampled in cycle t → busy=1 and src_ready eligible in cycle t+1.
- Final pop in cycle t → done=1 in t+1 → busy=0 in t+2.
- Counter updates and state transitions are registered on the rising clock edge.

## Configuration
- CANNY_FRAME_TIMEOUT_EN defined:
  - A stall counter runs in RUN and DRAIN; it clears on every pop and on start.
  - When it reaches TIMEOUT_CYCLES: timeout_err=1 (sticky) and FSM → IDLE (abort). No done pulse; frame_cnt is unchanged.
  - timeout_err clears on the next accepted start.
- CANNY_FRAME_TIMEOUT_EN undefined: no stall counter, timeout_err tied to 0, TIMEOUT_CYCLES ignored.

## Structure
- Shared package canny_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the function pixel_count(WIDTH, HEIGHT);
  - the counter-width constant derivation.
- One sub-module, frame_counter: a parameterised saturating-compare counter with clear, inc and at_limit. Instantiated twice (in_cnt, out_cnt).
- The stall counter is inline, inside the CANNY_FRAME_TIMEOUT_EN guard.

## Test plan
All scenarios use WIDTH=4, HEIGHT=3, PIXELS=12.
- Reset then idle: src_valid=1 with no start → src_ready stays 0 and busy=0 for 20 cycles.
- Single frame, no backpressure: start, 12 source pixels, loopback model returns 12 pixels → 12 image_wr_en, 12 pops, sink_last on the 12th pop, done one cycle later, frame_cnt=1.
- Overrun guard: host offers 20 pixels → exactly 12 accepted; src_ready=0 from the cycle after the 12th accept.
- Backpressure: image_full toggled every other cycle and sink_ready low for 5 cycles mid-frame → no writes while full, no pops while sink_ready=0, correct counts, one done pulse.
- start asserted in RUN and in DONE → ignored; a second start after IDLE runs frame 2 → frame_cnt=2.
- Stall (TIMEOUT_CYCLES=16, macro defined): model stops after 5 outputs → timeout_err=1 at the 16th stall cycle, busy=0, no done, frame_cnt unchanged. With the macro undefined: busy stays 1 and timeout_err stays 0.
